sort_floats_seq: RTL and testbench

//   Sequential sorter for N floating-point values sharing ONE f_less_or_equal instance.
//   - Accepts an unsorted vector over a valid/ready handshake.
//   - Runs a bubble sort, one compare/conditional swap per clock.
//   - Returns the vector in increasing order over a second valid/ready handshake.
//   - Sits beside the combinational sorters as the area-cheap, multi-cycle alternative.
//

---
 rtl/sort_floats_seq.sv | 179 +++++++++++++++++
 tb/tb_sort_floats_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_floats_seq.sv
// sort_floats_seq: multi-cycle bubble sorter for N floating-point values.
// One shared less-or-equal comparator is used, with one compare and optional
// swap per clock. Jobs come in and results go out over valid/ready handshakes.
// Optional feature macro: SORT_FLOATS_SEQ_EARLY_EXIT_EN. When it is defined,
// the sort finishes after the first pass that makes no swap.
module sort_floats_seq #(
    parameter int unsigned N    = 3,
    parameter int unsigned FLEN = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                up_valid,
    output logic                up_ready,
    input  logic [N*FLEN-1:0]   up_data,
    output logic                down_valid,
    input  logic                down_ready,
    output logic [N*FLEN-1:0]   down_data,
    output logic                down_err,
    output logic                busy
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned PW = $clog2(N) + 1;
    localparam int unsigned EW = (FLEN == 64) ? 11 : ((FLEN == 32) ? 8 : 5);
    localparam int unsigned MW = FLEN - 1 - EW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SORT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [FLEN-1:0]   data_q [N];
    logic [FLEN-1:0]   data_d [N];
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     idx_nxt;
    logic [PW-1:0]     pass_q, pass_d;
    logic              err_q, err_d;
    logic              up_ready_q, busy_q, down_valid_q;
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
    logic              swap_seen_q, swap_seen_d;
`endif

    logic [FLEN-1:0]   cmp_a, cmp_b;
    logic              cmp_res, cmp_err;
    logic              a_nan, b_nan;
    logic              pass_end, last_pass;

    assign idx_nxt   = idx_q + IW'(1);
    assign cmp_a     = data_q[idx_q];
    assign cmp_b     = data_q[idx_nxt];
    assign pass_end  = (32'(idx_q) + 32'(pass_q)) == (N - 2);
    assign last_pass = (32'(pass_q) + 32'd1) == (N - 1);

    // Shared comparator: res = (a <= b), err on any NaN operand; +0 equals -0
    always_comb begin : f_less_or_equal
        a_nan   = (&cmp_a[FLEN-2 -: EW]) && (|cmp_a[MW-1:0]);
        b_nan   = (&cmp_b[FLEN-2 -: EW]) && (|cmp_b[MW-1:0]);
        cmp_err = a_nan | b_nan;
        cmp_res = 1'b0;
        if (!cmp_err) begin
            if ((cmp_a[FLEN-2:0] == '0) && (cmp_b[FLEN-2:0] == '0)) begin
                cmp_res = 1'b1;
            end else if (cmp_a[FLEN-1] != cmp_b[FLEN-1]) begin
                cmp_res = cmp_a[FLEN-1];
            end else if (!cmp_a[FLEN-1]) begin
                cmp_res = cmp_a[FLEN-2:0] <= cmp_b[FLEN-2:0];
            end else begin
                cmp_res = cmp_a[FLEN-2:0] >= cmp_b[FLEN-2:0];
            end
        end
    end

    // Next-state: job capture, compare/swap stepping and result hand-off
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        err_d   = err_q;
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
        swap_seen_d = swap_seen_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (up_valid) begin
                    for (int unsigned i = 0; i < N; i++) begin
                        data_d[i] = up_data[(N-1-i)*FLEN +: FLEN];
                    end
                    idx_d   = '0;
                    pass_d  = '0;
                    err_d   = 1'b0;
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
                    swap_seen_d = 1'b0;
`endif
                    state_d = S_SORT;
                end
            end
            S_SORT: begin
                if (cmp_err) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    if (!cmp_res) begin
                        data_d[idx_q]   = cmp_b;
                        data_d[idx_nxt] = cmp_a;
                    end
                    if (pass_end) begin
                        idx_d  = '0;
                        pass_d = pass_q + PW'(1);
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
                        swap_seen_d = 1'b0;
                        if (last_pass || !(swap_seen_q || !cmp_res)) begin
                            state_d = S_DONE;
                        end
`else
                        if (last_pass) begin
                            state_d = S_DONE;
                        end
`endif
                    end else begin
                        idx_d = idx_nxt;
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
                        swap_seen_d = swap_seen_q | ~cmp_res;
`endif
                    end
                end
            end
            S_DONE: begin
                if (down_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            for (int unsigned i = 0; i < N; i++) begin
                data_q[i] <= '0;
            end
            idx_q        <= '0;
            pass_q       <= '0;
            err_q        <= 1'b0;
            up_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            down_valid_q <= 1'b0;
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
            swap_seen_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            idx_q        <= idx_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            up_ready_q   <= (state_d == S_IDLE);
            busy_q       <= (state_d == S_SORT);
            down_valid_q <= (state_d == S_DONE);
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
            swap_seen_q  <= swap_seen_d;
`endif
        end
    end

    assign up_ready   = up_ready_q;
    assign busy       = busy_q;
    assign down_valid = down_valid_q;
    assign down_err   = err_q;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign down_data[(N-1-g)*FLEN +: FLEN] = data_q[g];
    end

endmodule

// File: tb/tb_sort_floats_seq.sv
// Bench for sort_floats_seq: directed cases plus randomized jobs checked
// against a stable insertion-sort reference on real values.
module tb_sort_floats_seq;

    localparam int N     = 3;
    localparam int FLEN  = 64;
    localparam int LIMIT = 40;

    localparam logic [63:0] F_P1   = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] F_P2   = 64'h4000_0000_0000_0000;
    localparam logic [63:0] F_P3   = 64'h4008_0000_0000_0000;
    localparam logic [63:0] F_P5   = 64'h4014_0000_0000_0000;
    localparam logic [63:0] F_M1   = 64'hBFF0_0000_0000_0000;
    localparam logic [63:0] F_M2   = 64'hC000_0000_0000_0000;
    localparam logic [63:0] F_PZ   = 64'h0000_0000_0000_0000;
    localparam logic [63:0] F_MZ   = 64'h8000_0000_0000_0000;
    localparam logic [63:0] F_NAN  = 64'h7FF8_0000_0000_0000;

    logic clk = 1'b0;
    logic rst, up_valid, up_ready, down_valid, down_ready, down_err, busy;
    logic [N*FLEN-1:0] up_data, down_data;

    always #5 clk = ~clk;

    sort_floats_seq #(.N(N), .FLEN(FLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .down_err   (down_err),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] job_in  [N];
    logic [63:0] exp_out [N];
    logic [63:0] got_out [N];
    logic        exp_err, got_err;
    int          exp_lat, got_lat;
    logic        got_ready0, got_busy1, got_ready_after, got_valid_after;

    function automatic logic [N*FLEN-1:0] pack_job();
        logic [N*FLEN-1:0] v;
        for (int i = 0; i < N; i++) v[(N-1-i)*FLEN +: FLEN] = job_in[i];
        return v;
    endfunction

    function automatic logic [63:0] rand_val();
        if ($urandom_range(0, 7) == 0) return F_MZ;
        return $realtobits(real'(int'($urandom_range(0, 8)) - 4) * 1.5);
    endfunction

    // Reference: stable sort by real value, latency from the bubble-sort pass count
    task automatic model_job();
        logic [63:0] key;
        int          pos, compares;
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
        int          worst, cnt, passes;
`endif
        exp_out = job_in;
        exp_err = 1'b0;
        for (int i = 1; i < N; i++) begin
            key = exp_out[i];
            pos = i;
            while (pos > 0) begin
                if ($bitstoreal(exp_out[pos-1]) > $bitstoreal(key)) begin
                    exp_out[pos] = exp_out[pos-1];
                    pos--;
                end else break;
            end
            exp_out[pos] = key;
        end
        compares = N * (N - 1) / 2;
`ifdef SORT_FLOATS_SEQ_EARLY_EXIT_EN
        worst = 0;
        for (int i = 0; i < N; i++) begin
            cnt = 0;
            for (int m = 0; m < i; m++)
                if ($bitstoreal(job_in[m]) > $bitstoreal(job_in[i])) cnt++;
            if (cnt > worst) worst = cnt;
        end
        passes   = (worst + 1 < N - 1) ? worst + 1 : N - 1;
        compares = 0;
        for (int p = 0; p < passes; p++) compares += N - 1 - p;
`endif
        exp_lat = compares + 1;
    endtask

    task automatic run_job();
        @(negedge clk);
        got_ready0 = up_ready;
        up_data    = pack_job();
        up_valid   = 1'b1;
        @(negedge clk);
        up_valid  = 1'b0;
        got_busy1 = busy;
        got_lat   = 1;
        while (!down_valid && got_lat < LIMIT) begin
            @(negedge clk);
            got_lat++;
        end
        for (int i = 0; i < N; i++) got_out[i] = down_data[(N-1-i)*FLEN +: FLEN];
        got_err = down_err;
    endtask

    task automatic release_job();
        down_ready = 1'b1;
        @(negedge clk);
        down_ready      = 1'b0;
        got_ready_after = up_ready;
        got_valid_after = down_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; up_valid = 1'b0; down_ready = 1'b0; up_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (up_ready !== 1'b1 || down_valid !== 1'b0 || busy !== 1'b0 || down_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset flags: got rdy=%b vld=%b busy=%b err=%b expected 1 0 0 0",
                     up_ready, down_valid, busy, down_err);
        end
        n_checks++;
        if (down_data !== '0) begin
            n_fail++;
            $display("FAIL reset data: got %h expected 0", down_data);
        end
    endtask

    task automatic test_sort(input string name, input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] c);
        job_in[0] = a; job_in[1] = b; job_in[2] = c;
        model_job();
        run_job();
        n_checks++;
        if (got_ready0 !== 1'b1 || got_busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s handshake: got ready=%b busy=%b expected 1 1", name, got_ready0, got_busy1);
        end
        n_checks++;
        if (got_lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, got_lat, exp_lat);
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (got_out[i] !== exp_out[i]) begin
                n_fail++;
                $display("FAIL %s data[%0d]: got %h expected %h", name, i, got_out[i], exp_out[i]);
            end
        end
        n_checks++;
        if (got_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s err: got %b expected %b", name, got_err, exp_err);
        end
        release_job();
        n_checks++;
        if (got_ready_after !== 1'b1 || got_valid_after !== 1'b0) begin
            n_fail++;
            $display("FAIL %s release: got ready=%b valid=%b expected 1 0", name,
                     got_ready_after, got_valid_after);
        end
    endtask

    task automatic test_nan();
        job_in[0] = F_P1; job_in[1] = F_NAN; job_in[2] = F_P2;
        run_job();
        n_checks++;
        if (got_lat !== 2) begin
            n_fail++;
            $display("FAIL nan latency: got %0d expected 2", got_lat);
        end
        n_checks++;
        if (got_err !== 1'b1) begin
            n_fail++;
            $display("FAIL nan err: got %b expected 1", got_err);
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (got_out[i] !== job_in[i]) begin
                n_fail++;
                $display("FAIL nan data[%0d]: got %h expected %h", i, got_out[i], job_in[i]);
            end
        end
        release_job();
    endtask

    task automatic test_backpressure();
        logic [N*FLEN-1:0] snap;
        job_in[0] = F_P5; job_in[1] = F_M2; job_in[2] = F_P1;
        run_job();
        snap = down_data;
        n_checks++;
        if (snap !== {F_M2, F_P1, F_P5}) begin
            n_fail++;
            $display("FAIL backpressure data: got %h expected %h", snap, {F_M2, F_P1, F_P5});
        end
        up_data  = {F_P3, F_P2, F_P1};
        up_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (down_valid !== 1'b1 || up_ready !== 1'b0 || down_data !== snap) begin
                n_fail++;
                $display("FAIL backpressure hold cycle %0d: got vld=%b rdy=%b data=%h expected 1 0 %h",
                         c, down_valid, up_ready, down_data, snap);
            end
        end
        up_valid = 1'b0;
        release_job();
        n_checks++;
        if (got_ready_after !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure release: got ready=%b busy=%b expected 1 0",
                     got_ready_after, busy);
        end
    endtask

    task automatic test_reset_mid_sort();
        @(negedge clk);
        up_data  = {F_P3, F_P1, F_P2};
        up_valid = 1'b1;
        @(negedge clk);
        up_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (up_ready !== 1'b1 || down_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: got rdy=%b vld=%b busy=%b expected 1 0 0",
                     up_ready, down_valid, busy);
        end
        test_sort("after_midreset", F_P2, F_M1, F_P1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            test_sort("random", rand_val(), rand_val(), rand_val());
        end
    endtask

    initial begin
        test_reset();
        test_sort("basic", F_P3, F_P1, F_P2);
        test_sort("reverse", F_P3, F_P2, F_P1);
        test_sort("sorted", F_P1, F_P2, F_P3);
        test_nan();
        test_backpressure();
        test_reset_mid_sort();
        test_sort("duplicates", F_M2, F_P5, F_M2);
        test_sort("stable_zero", F_PZ, F_MZ, F_M1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
